// File: rtl/apb_mux_pkg.sv
// rtl/apb_mux_pkg.sv - shared state type, error data constant and index-width helper
package apb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACCESS     = 2'd1,
    ERR_ACCESS = 2'd2
  } state_t;

  localparam logic [63:0] ERR_DATA = '0;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_onehot_enc.sv
// rtl/apb_onehot_enc.sv - one-hot to index encoder with exactly-one and multi-hot flags
module apb_onehot_enc
  import apb_mux_pkg::*;
#(
  parameter int N     = 9,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             multi
);

  logic any;

  // OR-ing the indices is exact whenever valid is set, which is the only case idx is used
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        if (any) multi = 1'b1;
        any = 1'b1;
        idx = idx | IDX_W'(i);
      end
    end
    valid = any & ~multi;
  end

endmodule

// File: rtl/apb_resp_mux_param.sv
// rtl/apb_resp_mux_param.sv - APB return-path mux: latched slave select, decode error and stall watchdog
module apb_resp_mux_param
  import apb_mux_pkg::*;
#(
  parameter int NUM_SLAVES  = 9,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int IDX_W       = clog2_min1(NUM_SLAVES)
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [NUM_SLAVES-1:0]        PSEL_VEC,
  input  logic                         PSEL_DEF,
  input  logic                         PENABLE,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_VEC,
  input  logic [NUM_SLAVES-1:0]        PREADY_VEC,
  input  logic [NUM_SLAVES-1:0]        PSLVERR_VEC,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         err_decode,
  output logic                         err_timeout,
  output logic                         err_proto
);

  localparam int              CNT_W   = clog2_min1(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sel_idx, enc_idx;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             enc_valid, enc_multi;
  logic             start, setup_ok, free, take;
  logic             slv_ready, slv_err, slv_sel;
  logic             proto_hit, timeout_hit;
  logic [DATA_W-1:0] slv_data [NUM_SLAVES];

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_slice
    assign slv_data[k] = PRDATA_VEC[k*DATA_W +: DATA_W];
  end

  apb_onehot_enc #(
    .N     (NUM_SLAVES),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec   (PSEL_VEC),
    .idx   (enc_idx),
    .valid (enc_valid),
    .multi (enc_multi)
  );

  assign start     = (|PSEL_VEC | PSEL_DEF) & ~PENABLE;
  assign setup_ok  = enc_valid & ~enc_multi & ~PSEL_DEF;
  assign slv_ready = PREADY_VEC[sel_idx];
  assign slv_err   = PSLVERR_VEC[sel_idx];
  assign slv_sel   = PSEL_VEC[sel_idx];

  // A select dropped in the same cycle the slave answers is a normal completion, not a violation
  assign proto_hit   = (state == ACCESS) & ~slv_sel & ~slv_ready;
  assign timeout_hit = (TIMEOUT_CYC > 0) & (state == ACCESS) & ~proto_hit & ~slv_ready &
                       (wait_cnt == CNT_LIM);

  // free: the FSM can accept a new setup this cycle (idle, or a transfer is completing)
  assign free = (state == IDLE) | (state == ERR_ACCESS) | ((state == ACCESS) & PREADY);
  assign take = start & free;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      sel_idx     <= '0;
      wait_cnt    <= '0;
      err_decode  <= 1'b0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      err_decode  <= (state == ERR_ACCESS);
      err_timeout <= timeout_hit;
      err_proto   <= proto_hit;
      if (take && setup_ok) sel_idx <= enc_idx;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    if (take) begin
      state_nxt = setup_ok ? ACCESS : ERR_ACCESS;
    end else if (free || proto_hit) begin
      state_nxt = IDLE;
    end
    if (state == ACCESS && !PREADY && !proto_hit) begin
      wait_cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    case (state)
      ACCESS: begin
        if (timeout_hit) begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
          PRDATA  = ERR_DATA[DATA_W-1:0];
        end else if (!proto_hit) begin
          PREADY  = slv_ready;
          PSLVERR = slv_err;
          PRDATA  = slv_data[sel_idx];
        end
      end
      ERR_ACCESS: begin
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = ERR_DATA[DATA_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_resp_mux_param.sv
// tb/tb_apb_resp_mux_param.sv - scoreboard bench for apb_resp_mux_param with directed transfers
module tb_apb_resp_mux_param;

  localparam int NS = 9;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [NS-1:0]   PSEL_VEC;
  logic            PSEL_DEF;
  logic            PENABLE;
  logic [NS*DW-1:0] PRDATA_VEC;
  logic [NS-1:0]   PREADY_VEC;
  logic [NS-1:0]   PSLVERR_VEC;
  logic            PREADY;
  logic            PSLVERR;
  logic [DW-1:0]   PRDATA;
  logic            err_decode;
  logic            err_timeout;
  logic            err_proto;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic          dec;
    logic          tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic exp_rdy = 1'b0;
  int   proto_req = 0;
  int   proto_seen = 0;
  logic pend_dec = 1'b0;
  logic pend_tmo = 1'b0;
  logic pend_proto = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 HCLK = ~HCLK;

  apb_resp_mux_param #(
    .NUM_SLAVES  (NS),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .PSEL_VEC    (PSEL_VEC),
    .PSEL_DEF    (PSEL_DEF),
    .PENABLE     (PENABLE),
    .PRDATA_VEC  (PRDATA_VEC),
    .PREADY_VEC  (PREADY_VEC),
    .PSLVERR_VEC (PSLVERR_VEC),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .PRDATA      (PRDATA),
    .err_decode  (err_decode),
    .err_timeout (err_timeout),
    .err_proto   (err_proto)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every cycle checks PREADY against the stimulus intent and error pulses
  // against what the previous cycle's completion promised; completions pop the scoreboard.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      check("reset_flags", 64'({PREADY, PSLVERR, err_decode, err_timeout, err_proto}), 64'(0));
      check("reset_prdata", 64'(PRDATA), 64'(0));
      pend_dec   = 1'b0;
      pend_tmo   = 1'b0;
      pend_proto = 1'b0;
      proto_seen = proto_req;
    end else begin
      check("err_decode", 64'(err_decode), 64'(pend_dec));
      check("err_timeout", 64'(err_timeout), 64'(pend_tmo));
      check("err_proto", 64'(err_proto), 64'(pend_proto));
      check("pready", 64'(PREADY), 64'(exp_rdy));
      pend_dec   = 1'b0;
      pend_tmo   = 1'b0;
      pend_proto = (proto_req != proto_seen);
      proto_seen = proto_req;
      if (PREADY) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(exp_q.size()), 64'(1));
        end else begin
          mon_e = exp_q.pop_front();
          check("prdata", 64'(PRDATA), 64'(mon_e.data));
          check("pslverr", 64'(PSLVERR), 64'(mon_e.err));
          pend_dec = mon_e.dec;
          pend_tmo = mon_e.tmo;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    PSEL_VEC    = '0;
    PSEL_DEF    = 1'b0;
    PENABLE     = 1'b0;
    PREADY_VEC  = '0;
    PSLVERR_VEC = '0;
    exp_rdy     = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic e, input logic dec, input logic tmo);
    exp_q.push_back('{data: d, err: e, dec: dec, tmo: tmo});
  endtask

  task automatic setup(input int slv, input logic [DW-1:0] d);
    idle_bus();
    PSEL_VEC[slv] = 1'b1;
    PRDATA_VEC[slv*DW +: DW] = d;
    cyc();
    PENABLE = 1'b1;
  endtask

  // Slave answers after `waits` stalled ACCESS cycles
  task automatic xfer(input int slv, input int waits, input logic perr, input logic [DW-1:0] d);
    setup(slv, d);
    for (int w = 0; w < waits; w++) cyc();
    PREADY_VEC[slv]  = 1'b1;
    PSLVERR_VEC[slv] = perr;
    exp_rdy = 1'b1;
    push(d, perr, 1'b0, 1'b0);
    cyc();
    idle_bus();
  endtask

  task automatic err_xfer(input logic [NS-1:0] sel, input logic def);
    idle_bus();
    PSEL_VEC   = sel;
    PSEL_DEF   = def;
    PREADY_VEC = '1;
    cyc();
    PENABLE = 1'b1;
    exp_rdy = 1'b1;
    push('0, 1'b1, 1'b1, 1'b0);
    cyc();
    idle_bus();
  endtask

  // Slave never answers: the watchdog forces the response on ACCESS cycle TO+1
  task automatic stall_xfer(input int slv, input logic [DW-1:0] d);
    setup(slv, d);
    for (int w = 0; w < TO; w++) cyc();
    exp_rdy = 1'b1;
    push('0, 1'b1, 1'b0, 1'b1);
    cyc();
    idle_bus();
  endtask

  initial begin
    HRESETn = 1'b0;
    idle_bus();
    for (int k = 0; k < NS; k++) PRDATA_VEC[k*DW +: DW] = 32'hC0DE_0000 | k;
    repeat (3) cyc();
    HRESETn = 1'b1;
    cyc();

    xfer(3, 2, 1'b0, 32'hDEAD_BEEF);
    xfer(4, 1, 1'b1, 32'h4444_0004);
    err_xfer('0, 1'b1);
    err_xfer(9'h006, 1'b0);
    stall_xfer(8, 32'h8888_0008);
    xfer(0, 0, 1'b0, 32'h0000_0A0A);

    // Back-to-back: slave 7 setup presented on slave 0's completion cycle
    setup(0, 32'h1111_0000);
    PRDATA_VEC[7*DW +: DW] = 32'h7777_0007;
    PENABLE    = 1'b0;
    PSEL_VEC   = 9'h080;
    PREADY_VEC = 9'h001;
    exp_rdy    = 1'b1;
    push(32'h1111_0000, 1'b0, 1'b0, 1'b0);
    cyc();
    PENABLE    = 1'b1;
    PREADY_VEC = 9'h080;
    push(32'h7777_0007, 1'b0, 1'b0, 1'b0);
    cyc();
    idle_bus();

    // Protocol violation: select drops while slave 5 is still stalling
    setup(5, 32'h5555_0005);
    cyc();
    PSEL_VEC = '0;
    proto_req++;
    #2;
    check("proto_prdata", 64'(PRDATA), 64'(0));
    cyc();
    idle_bus();
    cyc();

    // Reset on the third stalled ACCESS cycle of slave 2
    setup(2, 32'h2222_2222);
    cyc();
    cyc();
    #2;
    check("access_prdata", 64'(PRDATA), 64'(32'h2222_2222));
    HRESETn = 1'b0;
    #1;
    check("async_rst_prdata", 64'(PRDATA), 64'(0));
    check("async_rst_ready", 64'({PREADY, PSLVERR}), 64'(0));
    idle_bus();
    cyc();
    cyc();
    HRESETn = 1'b1;
    cyc();

    stall_xfer(8, 32'h8888_0008);
    xfer(1, 0, 1'b0, 32'h1234_5678);
    repeat (3) cyc();

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
